control_unit: RTL and testbench
===============================

# control_unit

Moore-style control FSM that sequences the 16-bit programmable processor datapath: program counter, instruction register, data memory, register file and ALU. Decodes the 16-bit instruction held in the IR and drives every datapath enable, address and select. Exports its current and next state for the top-level debug outputs. Holds in HALT until reset.

## Interface
Parameters:
- none; widths are fixed by the shared package.

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; forces INIT
- IR  in  16  instruction register contents from the datapath
- PC_Clr  out  1  clear program counter to 0
- PC_Up  out  1  increment program counter
- IR_Ld  out  1  load IR from instruction memory
- D_Addr  out  8  data memory address
- D_Wr  out  1  data memory write enable
- RF_s  out  1  register-file write mux: 1 = data memory, 0 = ALU
- RF_W_Addr  out  4  register-file write address
- RF_W_en  out  1  register-file write enable
- RF_Ra_Addr  out  4  register-file read port A address
- RF_Rb_Addr  out  4  register-file read port B address
- ALU_s0  out  3  ALU function select
- State  out  4  current state encoding
- NextState  out  4  combinational next-state encoding
- Halted  out  1  high while in HALT
- InstrCount  out  16  count of instructions decoded since reset

## Operation
- Instruction fields: op = IR[15:12]; Ra = IR[11:8]; Rb = IR[7:4]; Rw = IR[3:0]; addr = IR[7:0].
- Opcodes: 0 NOOP; 1 STORE (mem[addr] <- R[Ra]); 2 LOAD (R[Ra] <- mem[addr]); 3 ADD (R[Rw] <- R[Ra]+R[Rb]); 4 SUB (R[Rw] <- R[Ra]-R[Rb]); 5 HALT; 6-15 treated as NOOP.
- States: INIT(0), FETCH(1), DECODE(2), NOOP(3), LOAD_A(4), LOAD_B(5), STORE(6), ADD(7), SUB(8), HALT(9).
- Transitions: INIT -> FETCH; FETCH -> DECODE; DECODE -> state selected by op; LOAD_A -> LOAD_B; NOOP, LOAD_B, STORE, ADD, SUB -> FETCH; HALT -> HALT.
- Outputs per state (all others 0, addresses 0):
  - INIT: PC_Clr=1.
  - FETCH: IR_Ld=1, PC_Up=1.
  - LOAD_A: D_Addr=addr, RF_s=1, RF_W_Addr=Ra (memory read latency cycle).
  - LOAD_B: same as LOAD_A plus RF_W_en=1.
  - STORE: D_Addr=addr, RF_Ra_Addr=Ra, D_Wr=1.
  - ADD: RF_Ra_Addr=Ra, RF_Rb_Addr=Rb, RF_W_Addr=Rw, RF_W_en=1, ALU_s0=1.
  - SUB: as ADD with ALU_s0=2.
  - HALT: Halted=1.
- ALU_s0 is 0 in every state other than ADD and SUB.
- InstrCount increments by 1 on each DECODE cycle and wraps 0xFFFF -> 0x0000; HALT is counted.

## Timing
- Reset asserted: State=INIT immediately (asynchronous), InstrCount=0; outputs follow INIT decode (PC_Clr=1, all other control outputs 0). Reset mid-instruction abandons it; no write strobe is asserted after reset assertion.
- First FETCH occurs on the first rising edge after reset deassertion plus one cycle in INIT.
- Instruction cycle counts including FETCH and DECODE: NOOP/STORE/ADD/SUB = 3, LOAD = 4, HALT = 2 then stays.
- IR loads at the end of FETCH; DECODE and execute states read the new IR.
- NextState is purely combinational from State and IR; all control outputs depend on State and IR fields only (no input-to-output path other than through IR).

## Structure
- Shared package: state enum (4-bit, values above), opcode constants, ALU select constants (ALU_PASS=0, ALU_ADD=1, ALU_SUB=2), field-slice widths.
- Single module with a state register, next-state combinational block and output decode block; no sub-module.

## Test plan
- Reset then NOOP (IR=0x0000): states 0,1,2,3,1; PC_Up high exactly in FETCH; InstrCount=1 after DECODE.
- LOAD IR=0x2A1B: LOAD_A then LOAD_B with D_Addr=0x1B, RF_W_Addr=0xA, RF_s=1; RF_W_en high only in LOAD_B.
- STORE IR=0x1305: single STORE cycle, D_Addr=0x05, RF_Ra_Addr=3, D_Wr=1; RF_W_en stays 0.
- ADD IR=0x3127 then SUB IR=0x4127: RF_Ra_Addr=1, RF_Rb_Addr=2, RF_W_Addr=7, RF_W_en=1, ALU_s0=1 then 2.
- HALT IR=0x5000: State=9, Halted=1, PC_Up/IR_Ld stay 0 for 20+ cycles; asserting Reset mid-cycle returns State to 0 without waiting for Clk.
- Reset asserted during LOAD_A: no RF_W_en pulse; opcode 0xF (IR=0xF123) executes as NOOP.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types for the 16-bit processor control FSM:
// state encoding, opcodes, ALU selects and IR field widths.
package control_unit_pkg;

  localparam int IR_W   = 16;
  localparam int OP_W   = 4;
  localparam int REG_W  = 4;
  localparam int ADDR_W = 8;
  localparam int ALU_W  = 3;
  localparam int CNT_W  = 16;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [OP_W-1:0] OP_NOOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_STORE = 4'd1;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OP_W-1:0] OP_HALT  = 4'd5;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

  function automatic state_t op_state(
    input logic [OP_W-1:0] op
  );
    unique case (op)
      OP_STORE: op_state = S_STORE;
      OP_LOAD:  op_state = S_LOAD_A;
      OP_ADD:   op_state = S_ADD;
      OP_SUB:   op_state = S_SUB;
      OP_HALT:  op_state = S_HALT;
      OP_NOOP:  op_state = S_NOOP;
      default:  op_state = S_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath control bus: IR from the datapath,
// enables/addresses/selects back to it.
interface control_unit_if;
  import control_unit_pkg::*;

  logic [IR_W-1:0]   IR;
  logic              PC_Clr;
  logic              PC_Up;
  logic              IR_Ld;
  logic [ADDR_W-1:0] D_Addr;
  logic              D_Wr;
  logic              RF_s;
  logic [REG_W-1:0]  RF_W_Addr;
  logic              RF_W_en;
  logic [REG_W-1:0]  RF_Ra_Addr;
  logic [REG_W-1:0]  RF_Rb_Addr;
  logic [ALU_W-1:0]  ALU_s0;

  modport master (
    input  IR,
    output PC_Clr, PC_Up, IR_Ld,
    output D_Addr, D_Wr, RF_s,
    output RF_W_Addr, RF_W_en,
    output RF_Ra_Addr, RF_Rb_Addr,
    output ALU_s0
  );

  modport slave (
    output IR,
    input  PC_Clr, PC_Up, IR_Ld,
    input  D_Addr, D_Wr, RF_s,
    input  RF_W_Addr, RF_W_en,
    input  RF_Ra_Addr, RF_Rb_Addr,
    input  ALU_s0
  );

endinterface

// File: rtl/control_unit.sv
// Moore control FSM for the 16-bit processor datapath;
// outputs decode from current state and IR fields only.
module control_unit
  import control_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  control_unit_if.master   bus,
  output logic [3:0]       State,
  output logic [3:0]       NextState,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  state_t state_q;
  state_t state_d;

  logic [OP_W-1:0]   op;
  logic [REG_W-1:0]  ra;
  logic [REG_W-1:0]  rb;
  logic [REG_W-1:0]  rw;
  logic [ADDR_W-1:0] addr;

  assign op   = bus.IR[15:12];
  assign ra   = bus.IR[11:8];
  assign rb   = bus.IR[7:4];
  assign rw   = bus.IR[3:0];
  assign addr = bus.IR[7:0];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_INIT;
      InstrCount <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        InstrCount <= InstrCount + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = op_state(op);
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // LOAD_A covers memory read latency; write lands in LOAD_B
  always_comb begin
    bus.PC_Clr     = 1'b0;
    bus.PC_Up      = 1'b0;
    bus.IR_Ld      = 1'b0;
    bus.D_Addr     = '0;
    bus.D_Wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_Addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_Addr = '0;
    bus.RF_Rb_Addr = '0;
    bus.ALU_s0     = ALU_PASS;
    unique case (1'b1)
      (state_q == S_INIT): begin
        bus.PC_Clr = 1'b1;
      end
      (state_q == S_FETCH): begin
        bus.IR_Ld = 1'b1;
        bus.PC_Up = 1'b1;
      end
      (state_q == S_LOAD_A),
      (state_q == S_LOAD_B): begin
        bus.D_Addr    = addr;
        bus.RF_s      = 1'b1;
        bus.RF_W_Addr = ra;
        bus.RF_W_en   = (state_q == S_LOAD_B);
      end
      (state_q == S_STORE): begin
        bus.D_Addr     = addr;
        bus.RF_Ra_Addr = ra;
        bus.D_Wr       = 1'b1;
      end
      (state_q == S_ADD),
      (state_q == S_SUB): begin
        bus.RF_Ra_Addr = ra;
        bus.RF_Rb_Addr = rb;
        bus.RF_W_Addr  = rw;
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = (state_q == S_ADD)
                         ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign State     = state_q;
  assign NextState = state_d;
  assign Halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each opcode,
// HALT hold, async reset and reset mid-LOAD.
module tb_control_unit;

  logic        Clk;
  logic        Reset;
  logic [3:0]  State;
  logic [3:0]  NextState;
  logic        Halted;
  logic [15:0] InstrCount;

  int errors = 0;
  int checks = 0;

  control_unit_if bus ();

  control_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (bus.master),
    .State      (State),
    .NextState  (NextState),
    .Halted     (Halted),
    .InstrCount (InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  initial begin
    Reset  = 1'b1;
    bus.IR = 16'h0000;
    step();
    step();
    chk("rst_state", State, 0);
    chk("rst_pcclr", bus.PC_Clr, 1);
    chk("rst_count", InstrCount, 0);
    chk("rst_pcup", bus.PC_Up, 0);
    chk("rst_dwr", bus.D_Wr, 0);
    chk("rst_next", NextState, 1);

    // NOOP
    Reset = 1'b0;
    step();
    chk("noop_fetch", State, 1);
    chk("fetch_pcup", bus.PC_Up, 1);
    chk("fetch_irld", bus.IR_Ld, 1);
    chk("fetch_next", NextState, 2);
    step();
    chk("noop_dec", State, 2);
    chk("dec_pcup", bus.PC_Up, 0);
    chk("dec_next", NextState, 3);
    step();
    chk("noop_ex", State, 3);
    chk("noop_pcup", bus.PC_Up, 0);
    chk("noop_cnt", InstrCount, 1);
    step();
    chk("noop_back", State, 1);

    // LOAD
    bus.IR = 16'h2A1B;
    step();
    chk("ld_dec", State, 2);
    chk("ld_next", NextState, 4);
    step();
    chk("lda_state", State, 4);
    chk("lda_daddr", bus.D_Addr, 8'h1B);
    chk("lda_waddr", bus.RF_W_Addr, 4'hA);
    chk("lda_rfs", bus.RF_s, 1);
    chk("lda_wen", bus.RF_W_en, 0);
    chk("lda_alu", bus.ALU_s0, 0);
    step();
    chk("ldb_state", State, 5);
    chk("ldb_daddr", bus.D_Addr, 8'h1B);
    chk("ldb_waddr", bus.RF_W_Addr, 4'hA);
    chk("ldb_rfs", bus.RF_s, 1);
    chk("ldb_wen", bus.RF_W_en, 1);
    step();
    chk("ld_back", State, 1);

    // STORE
    bus.IR = 16'h1305;
    step();
    step();
    chk("st_state", State, 6);
    chk("st_daddr", bus.D_Addr, 8'h05);
    chk("st_ra", bus.RF_Ra_Addr, 3);
    chk("st_dwr", bus.D_Wr, 1);
    chk("st_wen", bus.RF_W_en, 0);
    chk("st_next", NextState, 1);
    step();
    chk("st_back", State, 1);

    // ADD
    bus.IR = 16'h3127;
    step();
    step();
    chk("add_state", State, 7);
    chk("add_ra", bus.RF_Ra_Addr, 1);
    chk("add_rb", bus.RF_Rb_Addr, 2);
    chk("add_rw", bus.RF_W_Addr, 7);
    chk("add_wen", bus.RF_W_en, 1);
    chk("add_alu", bus.ALU_s0, 1);
    chk("add_dwr", bus.D_Wr, 0);
    step();

    // SUB
    bus.IR = 16'h4127;
    step();
    step();
    chk("sub_state", State, 8);
    chk("sub_ra", bus.RF_Ra_Addr, 1);
    chk("sub_rb", bus.RF_Rb_Addr, 2);
    chk("sub_rw", bus.RF_W_Addr, 7);
    chk("sub_wen", bus.RF_W_en, 1);
    chk("sub_alu", bus.ALU_s0, 2);
    step();

    // HALT
    bus.IR = 16'h5000;
    step();
    chk("halt_next", NextState, 9);
    step();
    chk("halt_state", State, 9);
    chk("halt_flag", Halted, 1);
    chk("halt_cnt", InstrCount, 6);
    for (int i = 0; i < 22; i++) begin
      step();
      chk("halt_hold", State, 9);
      chk("halt_fetch",
          {bus.PC_Up, bus.IR_Ld}, 0);
    end
    chk("halt_cnt2", InstrCount, 6);

    // async reset between edges
    #2 Reset = 1'b1;
    #1;
    chk("areset_state", State, 0);
    chk("areset_pcclr", bus.PC_Clr, 1);
    chk("areset_halted", Halted, 0);
    chk("areset_cnt", InstrCount, 0);

    // reset during LOAD_A
    step();
    Reset = 1'b0;
    bus.IR = 16'h2A1B;
    step();
    chk("r2_fetch", State, 1);
    step();
    step();
    chk("r2_lda", State, 4);
    Reset = 1'b1;
    #1;
    chk("r2_abort", State, 0);
    for (int i = 0; i < 3; i++) begin
      chk("r2_nowen", bus.RF_W_en, 0);
      step();
    end
    chk("r2_cnt", InstrCount, 0);

    // opcode 0xF as NOOP
    Reset = 1'b0;
    bus.IR = 16'hF123;
    step();
    chk("f_fetch", State, 1);
    step();
    chk("f_next", NextState, 3);
    step();
    chk("f_state", State, 3);
    chk("f_wen", bus.RF_W_en, 0);
    chk("f_dwr", bus.D_Wr, 0);
    chk("f_cnt", InstrCount, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
